// File: rtl/hazard_stall_controller_if.sv
// Decode-stage hazard controller bus: pipeline register specifiers and control bits in,
// stall/flush controls and performance counters out.
interface hazard_stall_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] Rs_ID;
  logic [REG_W-1:0] Rt_ID;
  logic             Branch_ID;
  logic [REG_W-1:0] Rt_EX;
  logic [REG_W-1:0] WriteReg_EX;
  logic             RegWrite_EX;
  logic             MemToReg_EX;
  logic [REG_W-1:0] WriteReg_M;
  logic             MemToReg_M;
  logic             CntClear;
  logic             StallF;
  logic             StallD;
  logic             FlushE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Rs_ID, Rt_ID, Branch_ID, Rt_EX, WriteReg_EX, RegWrite_EX,
           MemToReg_EX, WriteReg_M, MemToReg_M, CntClear,
    input  StallF, StallD, FlushE, StallCount, FlushCount
  );

  modport slave (
    input  Rs_ID, Rt_ID, Branch_ID, Rt_EX, WriteReg_EX, RegWrite_EX,
           MemToReg_EX, WriteReg_M, MemToReg_M, CntClear,
    output StallF, StallD, FlushE, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-in-decode hazard detection with saturating stall and flush counters.
// Stall/flush are combinational (zero latency); a lw->beq pair holds one extra cycle.
module hazard_stall_controller #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_HOLD1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lwstall;
  logic w_brstall_alu;
  logic w_brstall_ld;
  logic w_brstall_ldm;
  logic w_hazard;
  logic w_hazard_out;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  function automatic logic f_dep(input logic [REG_W-1:0] i_dst,
                                 input logic [REG_W-1:0] i_rs,
                                 input logic [REG_W-1:0] i_rt);
    return (i_dst != '0) && ((i_dst == i_rs) || (i_dst == i_rt));
  endfunction

  assign w_lwstall     = bus.MemToReg_EX && f_dep(bus.Rt_EX, bus.Rs_ID, bus.Rt_ID);
  assign w_brstall_alu = bus.Branch_ID && bus.RegWrite_EX && !bus.MemToReg_EX
                         && f_dep(bus.WriteReg_EX, bus.Rs_ID, bus.Rt_ID);
  assign w_brstall_ld  = bus.Branch_ID && w_lwstall;
  assign w_brstall_ldm = bus.Branch_ID && bus.MemToReg_M
                         && f_dep(bus.WriteReg_M, bus.Rs_ID, bus.Rt_ID);

  assign w_hazard = (r_state == S_HOLD1) || w_lwstall || w_brstall_alu || w_brstall_ldm;

  // Gating with rst_n also masks X inputs during reset (X & 0 = 0).
  assign w_hazard_out = w_hazard & rst_n;

  assign bus.StallF     = w_hazard_out;
  assign bus.StallD     = w_hazard_out;
  assign bus.FlushE     = w_hazard_out;
  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_brstall_ld ? S_HOLD1 : S_IDLE;
        S_HOLD1: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.CntClear) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.StallD && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (bus.FlushE && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, hand-written corner sequences and
// randomized cycles checked against a rule-level model (counters narrowed to 4 bits).
module tb_hazard_stall_controller;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic [4:0] rt_ex;
    logic [4:0] wr_ex;
    logic       rw_ex;
    logic       m2r_ex;
    logic [4:0] wr_m;
    logic       m2r_m;
    logic       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model state: pending forced stall cycles and ideal counter value.
  int   m_extra;
  int   m_cnt;

  hazard_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int rs, int rt, int br, int rt_ex, int wr_ex, int rw_ex,
                              int m2r_ex, int wr_m, int m2r_m, int exp);
    vec_t v;
    v.rs     = 5'(rs);
    v.rt     = 5'(rt);
    v.br     = 1'(br);
    v.rt_ex  = 5'(rt_ex);
    v.wr_ex  = 5'(wr_ex);
    v.rw_ex  = 1'(rw_ex);
    v.m2r_ex = 1'(m2r_ex);
    v.wr_m   = 5'(wr_m);
    v.m2r_m  = 1'(m2r_m);
    v.exp    = 1'(exp);
    return v;
  endfunction

  function automatic bit reads(logic [4:0] dst, vec_t v);
    return (dst != 0) && (dst == v.rs || dst == v.rt);
  endfunction

  // Stall if a forced cycle is pending, or the decode instruction needs a value not yet available.
  function automatic bit model_haz(vec_t v);
    bit load_dep;
    load_dep = v.m2r_ex && reads(v.rt_ex, v);
    if (m_extra > 0) return 1'b1;
    if (load_dep) return 1'b1;
    if (v.br && v.rw_ex && !v.m2r_ex && reads(v.wr_ex, v)) return 1'b1;
    if (v.br && v.m2r_m && reads(v.wr_m, v)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_commit(vec_t v, bit clr, bit haz);
    if (m_extra > 0) m_extra = m_extra - 1;
    else if (v.br && v.m2r_ex && reads(v.rt_ex, v)) m_extra = 1;
    if (clr) m_cnt = 0;
    else if (haz) m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkc(string nm, logic [CNT_W-1:0] act, int exp);
    checks++;
    if (act !== CNT_W'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v, bit clr);
    bus.Rs_ID       = v.rs;
    bus.Rt_ID       = v.rt;
    bus.Branch_ID   = v.br;
    bus.Rt_EX       = v.rt_ex;
    bus.WriteReg_EX = v.wr_ex;
    bus.RegWrite_EX = v.rw_ex;
    bus.MemToReg_EX = v.m2r_ex;
    bus.WriteReg_M  = v.wr_m;
    bus.MemToReg_M  = v.m2r_m;
    bus.CntClear    = clr;
  endtask

  task automatic apply_x();
    bus.Rs_ID       = 'x;
    bus.Rt_ID       = 'x;
    bus.Branch_ID   = 1'bx;
    bus.Rt_EX       = 'x;
    bus.WriteReg_EX = 'x;
    bus.RegWrite_EX = 1'bx;
    bus.MemToReg_EX = 1'bx;
    bus.WriteReg_M  = 'x;
    bus.MemToReg_M  = 1'bx;
    bus.CntClear    = 1'bx;
  endtask

  task automatic chk_out(string nm, logic exp);
    chk1({nm, "_StallF"}, bus.StallF, exp);
    chk1({nm, "_StallD"}, bus.StallD, exp);
    chk1({nm, "_FlushE"}, bus.FlushE, exp);
  endtask

  // One pipeline cycle: drive just after posedge, sample at negedge, advance the model at posedge.
  task automatic run_cycle(vec_t v, bit clr, logic exp, string nm);
    bit mh;
    apply(v, clr);
    mh = model_haz(v);
    @(negedge clk);
    chk_out(nm, exp);
    @(posedge clk);
    #1;
    model_commit(v, clr, mh);
  endtask

  vec_t tbl[17];
  vec_t zero_v;
  vec_t lw2_v;
  vec_t lw2br_v;
  vec_t ldm2_v;
  vec_t rv;
  bit   rclr;
  bit   rexp;

  initial begin
    checks  = 0;
    errors  = 0;
    m_extra = 0;
    m_cnt   = 0;

    //          rs rt br rtex wrex rw m2r wrm m2rm exp
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(2, 0, 0, 2, 0, 0, 1, 0, 0, 1);
    tbl[2]  = mk(0, 2, 0, 2, 0, 0, 1, 0, 0, 1);
    tbl[3]  = mk(3, 4, 0, 2, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 5, 1, 0, 5, 1, 0, 0, 0, 1);
    tbl[6]  = mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 5, 1, 0, 5, 0, 0, 0, 0, 0);
    tbl[9]  = mk(7, 0, 1, 0, 0, 0, 0, 7, 1, 1);
    tbl[10] = mk(7, 0, 0, 0, 0, 0, 0, 7, 1, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(3, 0, 1, 3, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(9, 0, 0, 9, 9, 1, 1, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    zero_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw2_v   = mk(2, 0, 0, 2, 0, 0, 1, 0, 0, 1);
    lw2br_v = mk(2, 0, 1, 2, 0, 0, 1, 0, 0, 1);
    ldm2_v  = mk(2, 0, 1, 0, 0, 0, 0, 2, 1, 1);

    // Reset with X inputs: outputs must be clean zeros.
    rst_n = 1'b0;
    apply_x();
    #12;
    chk_out("reset_x", 1'b0);
    chkc("reset_StallCount", bus.StallCount, 0);
    chkc("reset_FlushCount", bus.FlushCount, 0);
    apply(zero_v, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      run_cycle(tbl[i], 1'b0, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    chkc("tbl_StallCount", bus.StallCount, m_cnt);
    chkc("tbl_FlushCount", bus.FlushCount, m_cnt);

    // lw -> beq: two consecutive stalls, then clear.
    run_cycle(zero_v, 1'b1, 1'b0, "clr_a");
    run_cycle(lw2br_v, 1'b0, 1'b1, "lwbeq_c1");
    run_cycle(ldm2_v, 1'b0, 1'b1, "lwbeq_c2");
    run_cycle(zero_v, 1'b0, 1'b0, "lwbeq_c3");
    chkc("lwbeq_StallCount", bus.StallCount, 2);

    // Reset during HOLD1 drops the forced stall and clears counters.
    run_cycle(lw2br_v, 1'b0, 1'b1, "hold_enter");
    apply(zero_v, 1'b0);
    #1;
    chk_out("hold1_forced", 1'b1);
    rst_n = 1'b0;
    apply_x();
    #1;
    chk_out("rst_in_hold", 1'b0);
    chkc("rst_in_hold_StallCount", bus.StallCount, 0);
    chkc("rst_in_hold_FlushCount", bus.FlushCount, 0);
    m_extra = 0;
    m_cnt   = 0;
    @(negedge clk);
    chk_out("rst_hold_x", 1'b0);
    apply(zero_v, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_rst_idle", 1'b0);
    @(posedge clk);
    #1;
    run_cycle(zero_v, 1'b0, 1'b0, "post_rst_c2");
    chkc("post_rst_StallCount", bus.StallCount, 0);

    // Saturation at MAXC, then clear wins over a same-cycle stall.
    for (int i = 0; i < MAXC - 1; i++) begin
      run_cycle(lw2_v, 1'b0, 1'b1, "sat_fill");
    end
    chkc("sat_near_StallCount", bus.StallCount, MAXC - 1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(lw2_v, 1'b0, 1'b1, "sat_over");
    end
    chkc("sat_StallCount", bus.StallCount, MAXC);
    chkc("sat_FlushCount", bus.FlushCount, MAXC);
    run_cycle(lw2_v, 1'b1, 1'b1, "clr_vs_stall");
    chkc("clr_StallCount", bus.StallCount, 0);
    chkc("clr_FlushCount", bus.FlushCount, 0);

    // Randomized cycles on a narrow register range so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      rv = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 0);
      rclr = ($urandom_range(0, 24) == 0);
      rexp = model_haz(rv);
      run_cycle(rv, rclr, rexp, "rand");
      chkc("rand_StallCount", bus.StallCount, m_cnt);
      chkc("rand_FlushCount", bus.FlushCount, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
